game_frame_rx: RTL and testbench



---
 rtl/game_frame_rx_pkg.sv | 42 ++++
 rtl/game_frame_timer.sv | 28 ++
 rtl/game_frame_rx.sv | 197 +++++++++++++++++++
 tb/tb_game_frame_rx.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_frame_rx_pkg.sv
// Shared link definitions: screen limits, player ids, frame layout
// and the game-state bundle exchanged between boards.
package game_frame_rx_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;

    localparam logic [1:0] PLAYER_1 = 2'd1;
    localparam logic [1:0] PLAYER_2 = 2'd2;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         FRAME_LEN = 10;
    localparam int         HP_MAX    = 100;

    localparam int IDX_SYNC = 0;
    localparam int IDX_X_HI = 1;
    localparam int IDX_X_LO = 2;
    localparam int IDX_Y_HI = 3;
    localparam int IDX_Y_LO = 4;
    localparam int IDX_HP1  = 5;
    localparam int IDX_HP2  = 6;
    localparam int IDX_WIND = 7;
    localparam int IDX_TURN = 8;
    localparam int IDX_CSUM = FRAME_LEN - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CHECK_SUM,
        ST_VALIDATE
    } rx_state_t;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic [6:0]  hp1;
        logic [6:0]  hp2;
        logic [7:0]  wind;
        logic [1:0]  turn;
    } game_state_t;

endpackage

// File: rtl/game_frame_timer.sv
// Saturating timeout counter: counts every cycle unless cleared,
// holds at LIMIT and flags expiry while there.
module game_frame_timer #(
    parameter int LIMIT = 600000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count != W'(LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == W'(LIMIT));

endmodule

// File: rtl/game_frame_rx.sv
// Receive-side decoder for the game-state link: parses 10-byte frames
// into a shadow bank and publishes them atomically once validated.
module game_frame_rx #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         BYTE_TIMEOUT = 600000,
    parameter int         LINK_TIMEOUT = 6000000,
    parameter int         HP_MAX       = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [10:0] proj_xpos,
    output logic [9:0]  proj_ypos,
    output logic [6:0]  hp_player1,
    output logic [6:0]  hp_player2,
    output logic [7:0]  wind,
    output logic [1:0]  turn,
    output logic        frame_valid,
    output logic        frame_error,
    output logic        link_ok
);

    import game_frame_rx_pkg::*;

    rx_state_t   r_state;
    rx_state_t   w_next;
    logic [3:0]  r_idx;
    logic [7:0]  r_crc;
    logic [7:0]  r_buf [IDX_X_HI:IDX_TURN];
    logic        r_csum_ok;
    game_state_t r_out;
    logic        r_frame_valid;
    logic        r_frame_error;
    logic        r_link_ok;

    logic        w_start;
    logic        w_store;
    logic        w_csum_cap;
    logic        w_commit;
    logic        w_reject;
    logic        w_timeout;
    logic        w_gap_clear;
    logic        w_gap_expired;
    logic        w_link_expired;
    logic        w_sync;
    logic        w_checks_ok;
    game_state_t w_shadow;

    assign w_sync = rx_valid && (rx_data == SYNC_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_sync) w_next = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    if (r_idx == 4'(IDX_CSUM - 1)) w_next = ST_CHECK_SUM;
                end else if (w_gap_expired) begin
                    w_next = ST_IDLE;
                end
            end
            ST_CHECK_SUM: begin
                if (rx_valid) w_next = ST_VALIDATE;
                else if (w_gap_expired) w_next = ST_IDLE;
            end
            ST_VALIDATE: w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_start     = 1'b0;
        w_store     = 1'b0;
        w_csum_cap  = 1'b0;
        w_commit    = 1'b0;
        w_reject    = 1'b0;
        w_timeout   = 1'b0;
        w_gap_clear = 1'b1;
        unique case (r_state)
            ST_IDLE: w_start = w_sync;
            ST_PAYLOAD: begin
                w_store     = rx_valid;
                w_gap_clear = rx_valid;
                w_timeout   = !rx_valid && w_gap_expired;
            end
            ST_CHECK_SUM: begin
                w_csum_cap  = rx_valid;
                w_gap_clear = rx_valid;
                w_timeout   = !rx_valid && w_gap_expired;
            end
            ST_VALIDATE: begin
                w_commit = w_checks_ok;
                w_reject = !w_checks_ok;
            end
            default: w_gap_clear = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_crc     <= '0;
            r_csum_ok <= 1'b0;
            for (int i = IDX_X_HI; i <= IDX_TURN; i++) r_buf[i] <= '0;
        end else if (w_start) begin
            r_idx     <= 4'(IDX_SYNC + 1);
            r_crc     <= '0;
            r_csum_ok <= 1'b0;
        end else if (w_store) begin
            r_buf[r_idx] <= rx_data;
            r_crc        <= r_crc ^ rx_data;
            r_idx        <= r_idx + 4'd1;
        end else if (w_csum_cap) begin
            r_csum_ok <= (rx_data == r_crc);
        end
    end

    assign w_shadow.x    = {r_buf[IDX_X_HI][2:0], r_buf[IDX_X_LO]};
    assign w_shadow.y    = {r_buf[IDX_Y_HI][1:0], r_buf[IDX_Y_LO]};
    assign w_shadow.hp1  = r_buf[IDX_HP1][6:0];
    assign w_shadow.hp2  = r_buf[IDX_HP2][6:0];
    assign w_shadow.wind = r_buf[IDX_WIND];
    assign w_shadow.turn = r_buf[IDX_TURN][1:0];

    // Reserved bits must be zero so stray bit flips are not absorbed.
    assign w_checks_ok = r_csum_ok
        && (w_shadow.x < 11'(HOR_PIXELS))
        && (w_shadow.y < 10'(VER_PIXELS))
        && (w_shadow.hp1 <= 7'(HP_MAX))
        && (w_shadow.hp2 <= 7'(HP_MAX))
        && ((w_shadow.turn == PLAYER_1) || (w_shadow.turn == PLAYER_2))
        && (r_buf[IDX_X_HI][7:3] == '0)
        && (r_buf[IDX_Y_HI][7:2] == '0)
        && !r_buf[IDX_HP1][7]
        && !r_buf[IDX_HP2][7]
        && (r_buf[IDX_TURN][7:2] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out.x       <= '0;
            r_out.y       <= '0;
            r_out.hp1     <= 7'(HP_MAX);
            r_out.hp2     <= 7'(HP_MAX);
            r_out.wind    <= '0;
            r_out.turn    <= PLAYER_1;
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;
            r_link_ok     <= 1'b0;
        end else begin
            r_frame_valid <= w_commit;
            r_frame_error <= w_reject || w_timeout;
            if (w_commit) r_out <= w_shadow;
            if (r_frame_valid) r_link_ok <= 1'b1;
            else if (w_link_expired) r_link_ok <= 1'b0;
        end
    end

    game_frame_timer #(
        .LIMIT(BYTE_TIMEOUT)
    ) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_gap_clear),
        .o_expired(w_gap_expired)
    );

    game_frame_timer #(
        .LIMIT(LINK_TIMEOUT)
    ) u_link_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (r_frame_valid),
        .o_expired(w_link_expired)
    );

    assign proj_xpos   = r_out.x;
    assign proj_ypos   = r_out.y;
    assign hp_player1  = r_out.hp1;
    assign hp_player2  = r_out.hp2;
    assign wind        = r_out.wind;
    assign turn        = r_out.turn;
    assign frame_valid = r_frame_valid;
    assign frame_error = r_frame_error;
    assign link_ok     = r_link_ok;

endmodule

// File: tb/tb_game_frame_rx.sv
// Self-checking bench for game_frame_rx: directed link scenarios plus
// randomized frames scored against a byte-level reference model.
module tb_game_frame_rx;

    localparam int BT = 40;
    localparam int LT = 400;

    typedef logic [7:0] frame_t [10];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [10:0] proj_xpos;
    logic [9:0]  proj_ypos;
    logic [6:0]  hp_player1;
    logic [6:0]  hp_player2;
    logic [7:0]  wind;
    logic [1:0]  turn;
    logic        frame_valid;
    logic        frame_error;
    logic        link_ok;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fv     = 0;
    int n_fe     = 0;

    int exp_x, exp_y, exp_h1, exp_h2, exp_w, exp_t;

    game_frame_rx #(
        .SYNC_BYTE   (8'hA5),
        .BYTE_TIMEOUT(BT),
        .LINK_TIMEOUT(LT),
        .HP_MAX      (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .proj_xpos  (proj_xpos),
        .proj_ypos  (proj_ypos),
        .hp_player1 (hp_player1),
        .hp_player2 (hp_player2),
        .wind       (wind),
        .turn       (turn),
        .frame_valid(frame_valid),
        .frame_error(frame_error),
        .link_ok    (link_ok)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_valid === 1'b1) n_fv <= n_fv + 1;
        if (frame_error === 1'b1) n_fe <= n_fe + 1;
    end

    function automatic logic [44:0] obs_vec();
        return {proj_xpos, proj_ypos, hp_player1, hp_player2, wind, turn};
    endfunction

    function automatic logic [44:0] exp_vec();
        return {11'(exp_x), 10'(exp_y), 7'(exp_h1), 7'(exp_h2),
                8'(exp_w), 2'(exp_t)};
    endfunction

    function automatic void model_reset();
        exp_x = 0; exp_y = 0; exp_h1 = 100; exp_h2 = 100;
        exp_w = 0; exp_t = 1;
    endfunction

    function automatic void set_chk(inout frame_t f);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 1; i <= 8; i++) c = c ^ f[i];
        f[9] = c;
    endfunction

    function automatic void build(input int x, input int y, input int h1,
                                  input int h2, input int w, input int t,
                                  output frame_t f);
        f[0] = 8'hA5;
        f[1] = 8'(x / 256);
        f[2] = 8'(x % 256);
        f[3] = 8'(y / 256);
        f[4] = 8'(y % 256);
        f[5] = 8'(h1);
        f[6] = 8'(h2);
        f[7] = 8'(w);
        f[8] = 8'(t);
        set_chk(f);
    endfunction

    // Reference acceptance rule, evaluated on whole byte values.
    function automatic bit model_accept(input frame_t f);
        logic [7:0] c;
        int x, y;
        c = 8'h00;
        for (int i = 1; i <= 8; i++) c = c ^ f[i];
        if (f[9] != c) return 1'b0;
        if (int'(f[1]) > 7 || int'(f[3]) > 3) return 1'b0;
        x = int'(f[1]) * 256 + int'(f[2]);
        y = int'(f[3]) * 256 + int'(f[4]);
        if (x >= 1024 || y >= 768) return 1'b0;
        if (int'(f[5]) > 100 || int'(f[6]) > 100) return 1'b0;
        if (int'(f[8]) != 1 && int'(f[8]) != 2) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_apply(input frame_t f);
        exp_x  = int'(f[1]) * 256 + int'(f[2]);
        exp_y  = int'(f[3]) * 256 + int'(f[4]);
        exp_h1 = int'(f[5]);
        exp_h2 = int'(f[6]);
        exp_w  = int'(f[7]);
        exp_t  = int'(f[8]);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_bytes(input frame_t f, input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(f[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        model_reset();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=%h", obs_vec(), exp_vec());
        end
        n_checks++;
        if ({frame_valid, frame_error, link_ok} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b want=000",
                     {frame_valid, frame_error, link_ok});
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_good_frame();
        frame_t f;
        build(800, 600, 100, 50, -10, 2, f);
        send_bytes(f, 0, 9);
        n_checks++;
        if (frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL good_early_valid got=%b want=0", frame_valid);
        end
        idle(1);
        model_apply(f);
        n_checks++;
        if (frame_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL good_valid_latency got=%b want=1", frame_valid);
        end
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL good_outputs got=%h want=%h", obs_vec(), exp_vec());
        end
        n_checks++;
        if (link_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL good_link_early got=%b want=0", link_ok);
        end
        idle(1);
        n_checks++;
        if ({link_ok, frame_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL good_link_rise got=%b want=10", {link_ok, frame_valid});
        end
    endtask

    task automatic test_bad_checksum();
        frame_t f;
        int fv0, fe0;
        build(800, 600, 100, 50, -10, 2, f);
        f[9] = f[9] ^ 8'h01;
        fv0 = n_fv; fe0 = n_fe;
        send_bytes(f, 0, 9);
        idle(3);
        n_checks++;
        if (n_fe - fe0 !== 1 || n_fv - fv0 !== 0) begin
            n_fail++;
            $display("FAIL bad_csum_pulses got fe=%0d fv=%0d want fe=1 fv=0",
                     n_fe - fe0, n_fv - fv0);
        end
        n_checks++;
        if (obs_vec() !== exp_vec() || link_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_csum_hold got=%h link=%b want=%h link=1",
                     obs_vec(), link_ok, exp_vec());
        end
    endtask

    task automatic test_out_of_range();
        frame_t f;
        int fv0, fe0;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: build(1024, 10, 10, 10, 0, 1, f);
                1: build(10, 768, 10, 10, 0, 1, f);
                2: build(10, 10, 101, 10, 0, 1, f);
                default: build(10, 10, 10, 10, 0, 3, f);
            endcase
            fv0 = n_fv; fe0 = n_fe;
            send_bytes(f, 0, 9);
            idle(3);
            n_checks++;
            if (n_fe - fe0 !== 1 || n_fv - fv0 !== 0) begin
                n_fail++;
                $display("FAIL range_%0d_pulses got fe=%0d fv=%0d want fe=1 fv=0",
                         k, n_fe - fe0, n_fv - fv0);
            end
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL range_%0d_hold got=%h want=%h",
                         k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_byte_timeout();
        frame_t f;
        int fv0, fe0;
        build(5, 6, 7, 8, 9, 1, f);
        fv0 = n_fv; fe0 = n_fe;
        send_bytes(f, 0, 4);
        idle(BT + 10);
        n_checks++;
        if (n_fe - fe0 !== 1 || n_fv - fv0 !== 0) begin
            n_fail++;
            $display("FAIL timeout_pulse got fe=%0d fv=%0d want fe=1 fv=0",
                     n_fe - fe0, n_fv - fv0);
        end
        build(321, 123, 77, 66, 100, 1, f);
        fv0 = n_fv; fe0 = n_fe;
        send_bytes(f, 0, 9);
        idle(3);
        model_apply(f);
        n_checks++;
        if (n_fv - fv0 !== 1 || n_fe - fe0 !== 0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL timeout_recover fv=%0d fe=%0d got=%h want=%h",
                     n_fv - fv0, n_fe - fe0, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_garbage_link();
        frame_t f;
        int fv0, fe0;
        build(1023, 767, 0, 100, -128, 2, f);
        fv0 = n_fv; fe0 = n_fe;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        send_bytes(f, 0, 9);
        idle(3);
        model_apply(f);
        n_checks++;
        if (n_fv - fv0 !== 1 || n_fe - fe0 !== 0) begin
            n_fail++;
            $display("FAIL garbage_pulses got fv=%0d fe=%0d want fv=1 fe=0",
                     n_fv - fv0, n_fe - fe0);
        end
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL garbage_outputs got=%h want=%h", obs_vec(), exp_vec());
        end
        idle(LT - 20);
        n_checks++;
        if (link_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL link_hold got=%b want=1", link_ok);
        end
        idle(40);
        n_checks++;
        if (link_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL link_drop got=%b want=0", link_ok);
        end
    endtask

    task automatic test_reset_midframe();
        frame_t f;
        int fv0, fe0;
        build(800, 600, 100, 50, -10, 2, f);
        send_bytes(f, 0, 5);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (obs_vec() !== exp_vec() || link_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs got=%h link=%b want=%h link=0",
                     obs_vec(), link_ok, exp_vec());
        end
        idle(2);
        rst = 1'b0;
        fv0 = n_fv; fe0 = n_fe;
        send_bytes(f, 6, 9);
        idle(BT + 10);
        n_checks++;
        if (n_fv - fv0 !== 0 || n_fe - fe0 !== 0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL midreset_tail fv=%0d fe=%0d got=%h want=%h",
                     n_fv - fv0, n_fe - fe0, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        frame_t f;
        int fv0, fe0;
        bit ok;
        logic [7:0] g;
        for (int n = 0; n < 30; n++) begin
            build($urandom_range(1100, 0), $urandom_range(800, 0),
                  $urandom_range(110, 0), $urandom_range(110, 0),
                  $urandom_range(255, 0), $urandom_range(3, 0), f);
            if ($urandom_range(7, 0) == 0) begin
                f[1 + $urandom_range(7, 0)] |= 8'h80;
                set_chk(f);
            end
            if ($urandom_range(3, 0) == 0)
                f[9] = f[9] ^ 8'(1 << $urandom_range(7, 0));
            ok = model_accept(f);
            fv0 = n_fv; fe0 = n_fe;
            repeat ($urandom_range(2, 0)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send_byte(g);
            end
            send_bytes(f, 0, 9);
            idle(3);
            if (ok) model_apply(f);
            n_checks++;
            if (n_fv - fv0 !== (ok ? 1 : 0)) begin
                n_fail++;
                $display("FAIL rand_%0d_valid got=%0d want=%0d",
                         n, n_fv - fv0, ok ? 1 : 0);
            end
            n_checks++;
            if (n_fe - fe0 !== (ok ? 0 : 1)) begin
                n_fail++;
                $display("FAIL rand_%0d_error got=%0d want=%0d",
                         n, n_fe - fe0, ok ? 0 : 1);
            end
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rand_%0d_outputs got=%h want=%h",
                         n, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_out_of_range();
        test_byte_timeout();
        test_garbage_link();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
